// File: rtl/bram_arb_pkg.sv
// Shared types and helpers for the BRAM port arbiter slice.
package bram_arb_pkg;

  typedef enum logic [0:0] {
    RSP_IDLE = 1'b0,
    RSP_PEND = 1'b1
  } rsp_state_e;

  // Index width for n entries, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant over req, search starting at an internal pointer.
module rr_arbiter
  import bram_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int IW = idx_width(N);

  logic [IW-1:0] ptr;
  logic [IW-1:0] gnt_idx;
  logic [N-1:0]  req_live;
  logic [N-1:0]  req_hi;
  logic [N-1:0]  pool;

  // Requesters at or above ptr get first pick; otherwise wrap to the lowest index.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path infers a latch.
    req_live = req & {N{~rst}};
    req_hi   = '0;
    for (int i = 0; i < N; i++) begin
      req_hi[i] = req_live[i] && (IW'(i) >= ptr);
    end
    pool    = (|req_hi) ? req_hi : req_live;
    gnt     = '0;
    gnt_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pool[i]) begin
        gnt     = '0;
        gnt[i]  = 1'b1;
        gnt_idx = IW'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance && (|gnt)) begin
      ptr <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one single-port BRAM (1-cycle read latency) between NUM_REQ requesters,
// with a one-deep response slot and read-data hold register per requester.
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int NUM_REQ         = 2,
  parameter int DATA_WIDTH      = 64,
  parameter int BRAM_ADDR_WIDTH = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  req_valid,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic [NUM_REQ*BRAM_ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0]     req_we,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]       req_wrdata,
  output logic [NUM_REQ-1:0]                  rsp_valid,
  input  logic [NUM_REQ-1:0]                  rsp_ready,
  output logic [NUM_REQ*DATA_WIDTH-1:0]       rsp_rddata,
  output logic                                bram_en,
  output logic [DATA_WIDTH/8-1:0]             bram_we,
  output logic [BRAM_ADDR_WIDTH-1:0]          bram_addr,
  output logic [DATA_WIDTH-1:0]               bram_wrdata,
  input  logic [DATA_WIDTH-1:0]               bram_rddata
);

  localparam int WB = DATA_WIDTH / 8;
  localparam int AW = BRAM_ADDR_WIDTH;

  rsp_state_e            rsp_state [NUM_REQ];
  logic [NUM_REQ-1:0]    rd_flag;
  logic [NUM_REQ-1:0]    latched;
  logic [DATA_WIDTH-1:0] hold [NUM_REQ];
  logic [NUM_REQ-1:0]    eligible;
  logic [NUM_REQ-1:0]    gnt;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid[i] = (rsp_state[i] == RSP_PEND);
    end
  end

  // A requester may issue only when its response slot is free or draining now.
  assign eligible  = req_valid & (~rsp_valid | rsp_ready);
  assign req_ready = gnt;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (eligible),
    .advance (|gnt),
    .gnt     (gnt)
  );

  always_comb begin
    bram_en     = |gnt;
    bram_we     = '0;
    bram_addr   = '0;
    bram_wrdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        bram_we     = req_we[i*WB +: WB];
        bram_addr   = req_addr[i*AW +: AW];
        bram_wrdata = req_wrdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // A new grant implies the old response is either absent or consumed this cycle,
  // so it simply replaces the slot with no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        rsp_state[i] <= RSP_IDLE;
        rd_flag[i]   <= 1'b0;
        latched[i]   <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gnt[i]) begin
          rsp_state[i] <= RSP_PEND;
          rd_flag[i]   <= ~|req_we[i*WB +: WB];
          latched[i]   <= 1'b0;
        end else if (rsp_valid[i] && rsp_ready[i]) begin
          rsp_state[i] <= RSP_IDLE;
          latched[i]   <= 1'b0;
        end else if (rsp_valid[i] && rd_flag[i]) begin
          latched[i]   <= 1'b1;
        end
      end
    end
  end

  // NOTE: hold registers carry data only; they are qualified by latched and need no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rsp_valid[i] && !rsp_ready[i] && !latched[i] && rd_flag[i]) begin
        hold[i] <= bram_rddata;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_rddata[i*DATA_WIDTH +: DATA_WIDTH] = latched[i] ? hold[i] : bram_rddata;
    end
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model (pointer integer, per-requester expected response, shadow memory).
module tb_bram_port_arbiter;

  localparam int N  = 3;
  localparam int DW = 64;
  localparam int AW = 16;
  localparam int WB = DW / 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_ready;
  logic [N*AW-1:0]   req_addr = '0;
  logic [N*WB-1:0]   req_we = '0;
  logic [N*DW-1:0]   req_wrdata = '0;
  logic [N-1:0]      rsp_valid;
  logic [N-1:0]      rsp_ready = '1;
  logic [N*DW-1:0]   rsp_rddata;
  logic              bram_en;
  logic [WB-1:0]     bram_we;
  logic [AW-1:0]     bram_addr;
  logic [DW-1:0]     bram_wrdata;
  logic [DW-1:0]     bram_rddata;

  int n_tests = 0;
  int n_fail  = 0;

  bram_port_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .BRAM_ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_we(req_we), .req_wrdata(req_wrdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rddata(rsp_rddata),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_wrdata(bram_wrdata), .bram_rddata(bram_rddata)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Physical BRAM: read-first, output scrambled whenever not enabled.
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (bram_en) begin
      bram_rddata <= mem[bram_addr[7:0]];
      for (int b = 0; b < WB; b++)
        if (bram_we[b]) mem[bram_addr[7:0]][b*8 +: 8] <= bram_wrdata[b*8 +: 8];
    end else begin
      bram_rddata <= {$urandom, $urandom};
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model state.
  logic [DW-1:0] ref_mem [256];
  int            m_ptr = 0;
  bit            m_pend [N];
  bit            m_isrd [N];
  logic [DW-1:0] m_data [N];

  logic [N-1:0]  elig;
  logic [N-1:0]  exp_rdy;
  int            g;
  int            j;
  int            a;

  always @(negedge clk) begin
    if (rst) begin
      check("rst_req_ready", req_ready, 0);
      check("rst_bram_en", bram_en, 0);
      m_ptr = 0;
      for (int i = 0; i < N; i++) m_pend[i] = 0;
    end else begin
      for (int i = 0; i < N; i++) elig[i] = req_valid[i] && (!m_pend[i] || rsp_ready[i]);
      g = -1;
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (g < 0 && elig[j]) g = j;
      end
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      check("req_ready", req_ready, exp_rdy);
      check("bram_en", bram_en, (g >= 0) ? 1 : 0);
      if (g >= 0) begin
        check("bram_addr", bram_addr, req_addr[g*AW +: AW]);
        check("bram_we", bram_we, req_we[g*WB +: WB]);
        check("bram_wrdata", bram_wrdata, req_wrdata[g*DW +: DW]);
      end else begin
        check("bram_we_idle", bram_we, 0);
      end
      for (int i = 0; i < N; i++) begin
        check($sformatf("rsp_valid[%0d]", i), rsp_valid[i], m_pend[i]);
        if (m_pend[i] && m_isrd[i])
          check($sformatf("rsp_rddata[%0d]", i), rsp_rddata[i*DW +: DW], m_data[i]);
      end
      for (int i = 0; i < N; i++)
        if (m_pend[i] && rsp_ready[i]) m_pend[i] = 0;
      if (g >= 0) begin
        a = int'(req_addr[g*AW +: 8]);
        m_pend[g] = 1;
        m_isrd[g] = (req_we[g*WB +: WB] == '0);
        m_data[g] = ref_mem[a];
        for (int b = 0; b < WB; b++)
          if (req_we[g*WB + b]) ref_mem[a][b*8 +: 8] = req_wrdata[g*DW + b*8 +: 8];
        m_ptr = (g + 1) % N;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] ad, input logic [WB-1:0] we,
                         input logic [DW-1:0] wd);
    req_addr[i*AW +: AW]   = ad;
    req_we[i*WB +: WB]     = we;
    req_wrdata[i*DW +: DW] = wd;
  endtask

  logic [N-1:0] fair_exp [6];
  logic [DW-1:0] init_word;

  initial begin
    for (int i = 0; i < 256; i++) begin
      init_word = {$urandom, $urandom};
      if (i == 16'h0010) init_word = 64'hDEADBEEF_00000001;
      if (i == 16'h0005) init_word = 64'h0000_0000_0000_1234;
      if (i == 16'h0020) init_word = 64'h01234567_89ABCDEF;
      mem[i]     <= init_word;
      ref_mem[i] = init_word;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state with nothing requested.
    @(negedge clk);
    check("post_reset_rsp_valid", rsp_valid, 0);
    check("post_reset_req_ready", req_ready, 0);
    tick();

    // Round-robin fairness with continuous requests.
    fair_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    for (int i = 0; i < N; i++) set_req(i, AW'(i + 1), '0, '0);
    req_valid = '1;
    rsp_ready = '1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check($sformatf("fair_grant_%0d", c), req_ready, fair_exp[c]);
      check($sformatf("fair_en_%0d", c), bram_en, 1);
      tick();
    end
    req_valid = '0;
    @(negedge clk);
    tick();

    // Single read.
    set_req(0, 16'h0010, '0, '0);
    req_valid = 3'b001;
    @(negedge clk);
    check("single_ready", req_ready, 3'b001);
    check("single_addr", bram_addr, 16'h0010);
    check("single_we", bram_we, 0);
    tick();
    req_valid = '0;
    @(negedge clk);
    check("single_rsp_valid", rsp_valid, 3'b001);
    check("single_rsp_data", rsp_rddata[0 +: DW], 64'hDEADBEEF_00000001);
    tick();

    // Backpressure hold on requester 1 while requester 0 keeps the BRAM busy.
    set_req(1, 16'h0005, '0, '0);
    req_valid = 3'b010;
    rsp_ready = 3'b101;
    @(negedge clk);
    check("bp_first_grant", req_ready, 3'b010);
    tick();
    req_valid = 3'b011;
    for (int c = 0; c < 4; c++) begin
      set_req(0, AW'(16'h0040 + c), '0, '0);
      @(negedge clk);
      check($sformatf("bp_hold_data_%0d", c), rsp_rddata[DW +: DW], 64'h1234);
      check($sformatf("bp_hold_valid_%0d", c), rsp_valid[1], 1);
      check($sformatf("bp_grant_%0d", c), req_ready, 3'b001);
      tick();
    end
    rsp_ready = '1;
    @(negedge clk);
    check("bp_drain_regrant", req_ready, 3'b010);
    tick();
    req_valid = '0;
    @(negedge clk);
    tick();

    // Partial write then read back.
    set_req(0, 16'h0020, 8'h0F, '1);
    req_valid = 3'b001;
    @(negedge clk);
    check("wr_ready", req_ready, 3'b001);
    check("wr_bram_we", bram_we, 8'h0F);
    tick();
    set_req(0, 16'h0020, '0, '0);
    @(negedge clk);
    check("wr_rsp_valid", rsp_valid[0], 1);
    check("rd_after_wr_ready", req_ready, 3'b001);
    tick();
    req_valid = '0;
    @(negedge clk);
    check("rd_after_wr_data", rsp_rddata[0 +: DW], 64'h01234567_FFFFFFFF);
    tick();

    // Pointer wrap from the last requester back to 0.
    set_req(1, 16'h0001, '0, '0);
    set_req(2, 16'h0002, '0, '0);
    req_valid = 3'b010;
    @(negedge clk);
    check("wrap_pre", req_ready, 3'b010);
    tick();
    req_valid = 3'b100;
    @(negedge clk);
    check("wrap_last", req_ready, 3'b100);
    tick();
    req_valid = 3'b111;
    @(negedge clk);
    check("wrap_to_zero", req_ready, 3'b001);
    tick();
    req_valid = '0;
    @(negedge clk);
    tick();

    // Reset the cycle after a read grant.
    set_req(1, 16'h0010, '0, '0);
    req_valid = 3'b010;
    @(negedge clk);
    check("mid_rst_grant", req_ready, 3'b010);
    tick();
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    @(negedge clk);
    check("mid_rst_ready", req_ready, 0);
    check("mid_rst_en", bram_en, 0);
    tick();
    rst = 1'b0;
    req_valid = 3'b110;
    @(negedge clk);
    check("after_rst_rsp_valid", rsp_valid, 0);
    check("after_rst_grant", req_ready, 3'b010);
    tick();
    req_valid = '0;
    rsp_ready = '1;
    repeat (2) tick();

    // Randomized traffic checked by the model every cycle.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      req_valid = N'($urandom);
      for (int i = 0; i < N; i++) begin
        rsp_ready[i] = ($urandom_range(0, 9) < 7);
        set_req(i, AW'($urandom_range(0, 255)),
                ($urandom_range(0, 1) == 0) ? '0 : WB'($urandom), {$urandom, $urandom});
      end
      tick();
    end
    rst = 1'b0;
    req_valid = '0;
    rsp_ready = '1;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
